// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - MIPS instruction encoder feeding instruction memory through a word FIFO
// Optional ENC_STATS_EN builds the saturating words-written counter; otherwise o_words_wr is tied to 0.
module instr_encoder #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          ADDR_W     = 10,
  parameter logic [31:0] PC_BASE    = 32'h0000_3000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [3:0]  i_in_mnem,
  input  logic [4:0]  i_in_rs,
  input  logic [4:0]  i_in_rt,
  input  logic [4:0]  i_in_rd,
  input  logic [4:0]  i_in_shamt,
  input  logic [15:0] i_in_imm,
  input  logic [25:0] i_in_jaddr,
  output logic        o_im_we,
  output logic [31:0] o_im_addr,
  output logic [31:0] o_im_wdata,
  input  logic        i_im_ack,
  output logic        o_err_illegal,
  output logic        o_wrapped,
  output logic [15:0] o_words_wr
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [31:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [ADDR_W-1:0]  r_widx;
  logic               r_err;
  logic               r_wrapped;
  logic [31:0]        w_enc;
  logic               w_legal;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_full;

  always_comb begin
    w_enc = 32'h0000_0000;
    case (i_in_mnem)
      4'd0:    w_enc = {6'h00, i_in_rs, i_in_rt, i_in_rd, 5'd0, 6'h20};
      4'd1:    w_enc = {6'h00, i_in_rs, i_in_rt, i_in_rd, 5'd0, 6'h22};
      4'd2:    w_enc = {6'h0D, i_in_rs, i_in_rt, i_in_imm};
      4'd3:    w_enc = {6'h23, i_in_rs, i_in_rt, i_in_imm};
      4'd4:    w_enc = {6'h2B, i_in_rs, i_in_rt, i_in_imm};
      4'd5:    w_enc = {6'h04, i_in_rs, i_in_rt, i_in_imm};
      4'd6:    w_enc = {6'h0F, 5'd0, i_in_rt, i_in_imm};
      4'd7:    w_enc = {6'h03, i_in_jaddr};
      4'd8:    w_enc = {6'h00, i_in_rs, 15'd0, 6'h08};
      4'd9:    w_enc = {6'h00, 5'd0, i_in_rt, i_in_rd, i_in_shamt, 6'h00};
      default: w_enc = 32'h0000_0000;
    endcase
  end

  assign w_legal    = (i_in_mnem <= 4'd10);
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_in_ready = !w_full && !i_flush;
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_push     = w_accept && w_legal;
  // flush suppresses the pop so the word being acknowledged is discarded with the rest
  assign w_pop      = o_im_we && i_im_ack && !i_flush;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_enc;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // WRITE is entered on the push edge so the word reaches IM one cycle after acceptance
  always_comb begin
    w_next_state = r_state;
    o_im_we      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_push || (r_count != '0)) begin
          w_next_state = WRITE;
        end
      end
      WRITE: begin
        o_im_we = 1'b1;
        if (w_pop && (r_count == CNT_W'(1)) && !w_push) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
    if (i_flush) begin
      w_next_state = IDLE;
    end
  end

  assign o_im_wdata = o_im_we ? r_mem[r_rd_ptr] : 32'h0000_0000;
  assign o_im_addr  = PC_BASE + {{(30-ADDR_W){1'b0}}, r_widx, 2'b00};

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_widx    <= '0;
      r_wrapped <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_accept && !w_legal;
      if (i_flush) begin
        r_widx <= '0;
      end else if (w_pop) begin
        r_widx <= r_widx + ADDR_W'(1);
        if (r_widx == {ADDR_W{1'b1}}) begin
          r_wrapped <= 1'b1;
        end
      end
    end
  end

  assign o_err_illegal = r_err;
  assign o_wrapped     = r_wrapped;

`ifdef ENC_STATS_EN
  logic [15:0] r_words_wr;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_words_wr <= 16'h0000;
    end else if (w_pop && (r_words_wr != 16'hFFFF)) begin
      r_words_wr <= r_words_wr + 16'h0001;
    end
  end

  assign o_words_wr = r_words_wr;
`else
  assign o_words_wr = 16'h0000;
`endif

endmodule
